la_up_arbiter: RTL and testbench
================================

Name: la_up_arbiter

Overview:
- Shares one upstream AXI-Stream master port between two sources: the user-project stream (UP) and the logic-analyzer trace stream (LA).
- Sits between the user project, the logic analyzer and the upstream AXIS switch, in the axis_clk domain.
- Arbitrates at packet granularity and honours the logic analyzer's FIFO high-priority request (la_hpri_req).
- Guards against starvation and against runaway packets that never assert tlast.

Parameters:
pDATA_WIDTH, 32, tdata width.
pMAX_BEATS, 64, maximum beats per granted packet before forced termination (2..256).
pHPRI_MAX, 4, maximum consecutive LA packets granted on high priority while UP is waiting (1..15).

Ports:
axis_clk  in  1  sole clock.
axis_rst  in  1  synchronous reset, active-high.
arb_en  in  1  when low, no new grant is issued; a packet in flight completes.
up_tdata  in  pDATA_WIDTH  user-project data.
up_tuser  in  2  user-project sideband.
up_tlast  in  1  user-project end of packet.
up_tvalid  in  1  user-project valid.
up_tready  out  1  ready to user project.
la_tdata  in  pDATA_WIDTH  LA trace data.
la_tuser  in  2  LA sideband.
la_tlast  in  1  LA end of packet.
la_tvalid  in  1  LA valid.
la_tready  out  1  ready to LA.
la_hpri_req  in  1  LA FIFO above high threshold.
m_tdata  out  pDATA_WIDTH  upstream data.
m_tstrb  out  4  constant 4'hF.
m_tkeep  out  4  constant 4'hF.
m_tuser  out  2  granted source tuser.
m_tlast  out  1  granted tlast, or forced tlast.
m_tvalid  out  1  upstream valid.
m_tready  in  1  upstream ready.
grant  out  2  one-hot grant: 01 = UP, 10 = LA, 00 = idle.
err_timeout  out  1  sticky flag: a packet was force-terminated.
err_clr  in  1  clears err_timeout.

Behaviour:
- Reset values:
  - state IDLE; grant 00; all valid and ready outputs 0; m_tlast 0; m_tdata 0.
  - last_gnt = LA, so UP wins the first tie.
  - beat_cnt 0; hpri_cnt 0; err_timeout 0.
- States: IDLE, GNT_UP, GNT_LA. One registered state; all output muxing is combinational from state.
- IDLE:
  - m_tvalid, up_tready and la_tready are 0.
  - Decision is evaluated each cycle when arb_en is 1. Priority, first match wins:
    1. la_hpri_req & la_tvalid & (hpri_cnt < pHPRI_MAX) -> GNT_LA; hpri_cnt++ if up_tvalid.
    2. Both valid -> grant the source that is not last_gnt.
    3. Only one source valid -> grant it.
  - Granting UP clears hpri_cnt.
  - When la_hpri_req is 0 in IDLE, hpri_cnt clears.
  - When hpri_cnt == pHPRI_MAX and up_tvalid is 1, rule 1 is blocked, so UP wins rule 2.
- GNT_x:
  - m_tvalid = x_tvalid; x_tready = m_tready; the other source's tready = 0.
  - m_tdata and m_tuser come from x; zero-latency passthrough.
  - A beat is accepted when m_tvalid & m_tready; beat_cnt increments on each accepted beat.
  - m_tlast = x_tlast | (beat_cnt == pMAX_BEATS-1).
  - Exit: an accepted beat with m_tlast -> IDLE, last_gnt = x, beat_cnt = 0.
  - If the exit was forced (x_tlast = 0), set err_timeout. The remainder of x's packet re-arbitrates as a new packet.
- Throughput: one idle cycle between packets, so back-to-back single-beat packets run at 50%.
- Grant is held while x_tvalid drops mid-packet; no re-arbitration until tlast.
- arb_en deassert mid-packet: the packet completes, then the block stays in IDLE.
- la_hpri_req changes mid-packet: no effect until IDLE.
- err_timeout: err_clr has priority over a set in the same cycle.
- Synchronous reset mid-packet: state returns to IDLE next edge and readies drop; the upstream partial packet is not terminated (accepted system behaviour).
- beat_cnt is 8 bits; it never wraps because the forced exit occurs at pMAX_BEATS-1.

Test Plan:
- UP-only and LA-only streams:
  - UP sends 3-beat packets continuously -> grant 01, beats pass unmodified, one idle cycle between packets.
  - LA-only traffic behaves the same way with grant 10.
- Both tvalid, la_hpri_req = 0, 4-beat packets each -> grants alternate UP, LA, UP, LA; first grant UP after reset.
- la_hpri_req = 1 constant, both streaming 2-beat packets, pHPRI_MAX = 4 -> sequence LA ×4, UP ×1, LA ×4.
- UP sends 100 beats without tlast, pMAX_BEATS = 64 -> beat 64 carries m_tlast = 1, err_timeout = 1; LA is granted next if valid; err_clr clears the flag.
- m_tready toggles randomly and UP tvalid gaps occur mid-packet -> no beat is lost or duplicated, grant is held until tlast, la_tready stays 0.
- axis_rst asserted on beat 2 of a 4-beat LA packet -> next cycle grant = 00 and la_tready = 0; after release, normal arbitration resumes with UP winning the tie.

Source files
------------

// File: rtl/la_up_arbiter.sv
// Packet-granular arbiter sharing one upstream AXI-Stream master between the
// user-project stream and the logic-analyzer trace stream, with starvation and runaway-packet guards.
module la_up_arbiter #(
    parameter int pDATA_WIDTH = 32,
    parameter int pMAX_BEATS  = 64,
    parameter int pHPRI_MAX   = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   arb_en,
    input  logic [pDATA_WIDTH-1:0] up_tdata,
    input  logic [1:0]             up_tuser,
    input  logic                   up_tlast,
    input  logic                   up_tvalid,
    output logic                   up_tready,
    input  logic [pDATA_WIDTH-1:0] la_tdata,
    input  logic [1:0]             la_tuser,
    input  logic                   la_tlast,
    input  logic                   la_tvalid,
    output logic                   la_tready,
    input  logic                   la_hpri_req,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic [3:0]             m_tstrb,
    output logic [3:0]             m_tkeep,
    output logic [1:0]             m_tuser,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [1:0]             grant,
    output logic                   err_timeout,
    input  logic                   err_clr
);

    typedef enum logic [1:0] {IDLE, GNT_UP, GNT_LA} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(pMAX_BEATS - 1);
    localparam logic [3:0] HPRI_LIM  = 4'(pHPRI_MAX);

    state_t     state, state_nxt;
    logic       last_gnt_la, last_gnt_la_nxt;
    logic [7:0] beat_cnt, beat_cnt_nxt;
    logic [3:0] hpri_cnt, hpri_cnt_nxt;
    logic       err_set;
    logic       src_tlast;
    logic       beat_ok;
    logic       pkt_end;

    assign m_tstrb = 4'hF;
    assign m_tkeep = 4'hF;
    assign beat_ok = m_tvalid & m_tready;
    assign pkt_end = beat_ok & m_tlast;

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state       <= IDLE;
            last_gnt_la <= 1'b1;
            beat_cnt    <= 8'd0;
            hpri_cnt    <= 4'd0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_gnt_la <= last_gnt_la_nxt;
            beat_cnt    <= beat_cnt_nxt;
            hpri_cnt    <= hpri_cnt_nxt;
            if (err_clr)
                err_timeout <= 1'b0;
            else if (err_set)
                err_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_nxt       = state;
        last_gnt_la_nxt = last_gnt_la;
        beat_cnt_nxt    = beat_cnt;
        hpri_cnt_nxt    = hpri_cnt;
        err_set         = 1'b0;
        case (state)
            IDLE: begin
                if (!la_hpri_req)
                    hpri_cnt_nxt = 4'd0;
                if (arb_en) begin
                    // High-priority LA grants are capped only while UP is actually waiting.
                    if (la_hpri_req && la_tvalid && (hpri_cnt < HPRI_LIM)) begin
                        state_nxt = GNT_LA;
                        if (up_tvalid)
                            hpri_cnt_nxt = hpri_cnt + 4'd1;
                    end else if (up_tvalid && la_tvalid) begin
                        if (last_gnt_la) begin
                            state_nxt    = GNT_UP;
                            hpri_cnt_nxt = 4'd0;
                        end else begin
                            state_nxt = GNT_LA;
                        end
                    end else if (up_tvalid) begin
                        state_nxt    = GNT_UP;
                        hpri_cnt_nxt = 4'd0;
                    end else if (la_tvalid) begin
                        state_nxt = GNT_LA;
                    end
                end
            end
            default: begin
                if (beat_ok)
                    beat_cnt_nxt = beat_cnt + 8'd1;
                if (pkt_end) begin
                    state_nxt       = IDLE;
                    last_gnt_la_nxt = (state == GNT_LA);
                    beat_cnt_nxt    = 8'd0;
                    err_set         = !src_tlast;
                end
            end
        endcase
    end

    always_comb begin
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tuser   = 2'b00;
        src_tlast = 1'b0;
        up_tready = 1'b0;
        la_tready = 1'b0;
        grant     = 2'b00;
        case (state)
            GNT_UP: begin
                m_tvalid  = up_tvalid;
                m_tdata   = up_tdata;
                m_tuser   = up_tuser;
                src_tlast = up_tlast;
                up_tready = m_tready;
                grant     = 2'b01;
            end
            GNT_LA: begin
                m_tvalid  = la_tvalid;
                m_tdata   = la_tdata;
                m_tuser   = la_tuser;
                src_tlast = la_tlast;
                la_tready = m_tready;
                grant     = 2'b10;
            end
            default: ;
        endcase
        // Forced termination keeps beat_cnt from ever reaching pMAX_BEATS.
        m_tlast = (state != IDLE) && (src_tlast || (beat_cnt == LAST_BEAT));
    end

endmodule

// File: tb/tb_la_up_arbiter.sv
// Randomized scoreboard bench for la_up_arbiter: a packet-level reference model
// predicts grant order and the upstream beat stream; a monitor checks every cycle.
module tb_la_up_arbiter;

    localparam int DW   = 32;
    localparam int MAXB = 64;
    localparam int HMAX = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  user;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  user;
        logic        last;
        logic [1:0]  gnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          axis_rst, arb_en, la_hpri_req, err_clr, m_tready;
    logic [DW-1:0] up_tdata, la_tdata, m_tdata;
    logic [1:0]    up_tuser, la_tuser, m_tuser, grant;
    logic          up_tlast, up_tvalid, up_tready;
    logic          la_tlast, la_tvalid, la_tready;
    logic [3:0]    m_tstrb, m_tkeep;
    logic          m_tlast, m_tvalid, err_timeout;

    la_up_arbiter #(.pDATA_WIDTH(DW), .pMAX_BEATS(MAXB), .pHPRI_MAX(HMAX)) dut (
        .axis_clk(clk), .axis_rst(axis_rst), .arb_en(arb_en),
        .up_tdata(up_tdata), .up_tuser(up_tuser), .up_tlast(up_tlast),
        .up_tvalid(up_tvalid), .up_tready(up_tready),
        .la_tdata(la_tdata), .la_tuser(la_tuser), .la_tlast(la_tlast),
        .la_tvalid(la_tvalid), .la_tready(la_tready), .la_hpri_req(la_hpri_req),
        .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .grant(grant), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    beat_t up_q[$];
    beat_t la_q[$];
    exp_t  exp_q[$];

    // Reference model: owner 0 = none, 1 = UP, 2 = LA.
    int own = 0, last_own = 2, hpri = 0, remain = 0;
    bit forced = 0, err_m = 0;
    int up_pct = 100, la_pct = 100, rdy_pct = 100;
    bit rnd_ctl = 0, mon_en = 0;
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic void grant_to(input int src);
        int n = 0;
        int sz = (src == 1) ? up_q.size() : la_q.size();
        beat_t b;
        exp_t e;
        forced = 0;
        for (int i = 0; i < sz; i++) begin
            b = (src == 1) ? up_q[i] : la_q[i];
            n++;
            e.data = b.data;
            e.user = b.user;
            e.last = b.last || (n == MAXB);
            e.gnt  = (src == 1) ? 2'b01 : 2'b10;
            exp_q.push_back(e);
            if (e.last) begin
                forced = !b.last;
                break;
            end
        end
        remain = n;
        own = src;
    endfunction

    // Applies the rules to the inputs that were held across the edge just taken.
    function automatic void model_step();
        bit set_err = 0;
        bit acc;
        if (axis_rst) begin
            own = 0; last_own = 2; hpri = 0; remain = 0; err_m = 0;
            exp_q.delete(); up_q.delete(); la_q.delete();
            return;
        end
        if (own == 0) begin
            if (!la_hpri_req) hpri = 0;
            if (arb_en) begin
                if (la_hpri_req && la_tvalid && hpri < HMAX) begin
                    if (up_tvalid) hpri++;
                    grant_to(2);
                end else if (up_tvalid && la_tvalid) begin
                    if (last_own == 2) begin hpri = 0; grant_to(1); end
                    else grant_to(2);
                end else if (up_tvalid) begin
                    hpri = 0; grant_to(1);
                end else if (la_tvalid) begin
                    grant_to(2);
                end
            end
        end else begin
            acc = ((own == 1) ? up_tvalid : la_tvalid) && m_tready;
            if (acc) begin
                if (own == 1) void'(up_q.pop_front());
                else void'(la_q.pop_front());
                remain--;
                if (remain == 0) begin
                    last_own = own;
                    set_err = forced;
                    own = 0;
                end
            end
        end
        if (err_clr) err_m = 0;
        else if (set_err) err_m = 1;
    endfunction

    task automatic drive();
        up_tvalid = (up_q.size() > 0) && ($urandom_range(99) < up_pct);
        la_tvalid = (la_q.size() > 0) && ($urandom_range(99) < la_pct);
        {up_tdata, up_tuser, up_tlast} = (up_q.size() > 0) ? up_q[0] : beat_t'({$urandom, 3'($urandom)});
        {la_tdata, la_tuser, la_tlast} = (la_q.size() > 0) ? la_q[0] : beat_t'({$urandom, 3'($urandom)});
        m_tready = ($urandom_range(99) < rdy_pct);
        if (rnd_ctl) begin
            arb_en  = ($urandom_range(9) != 0);
            err_clr = ($urandom_range(19) == 0);
            if ($urandom_range(15) == 0) la_hpri_req = ~la_hpri_req;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        drive();
    endtask

    task automatic add_pkt(input int src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.user = 2'($urandom);
            b.last = (i == len - 1);
            if (src == 1) up_q.push_back(b);
            else la_q.push_back(b);
        end
    endtask

    task automatic reset_dut();
        axis_rst = 1'b1;
        cycle();
        axis_rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((up_q.size() > 0 || la_q.size() > 0 || own != 0) && k < budget) begin
            cycle();
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout at %0t: %0d beats still pending, required 0", $time, up_q.size() + la_q.size());
            reset_dut();
        end
        chk("exp_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: per-cycle control checks plus scoreboard pop on every upstream handshake.
    initial begin
        exp_t e;
        logic [1:0] eg;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                eg = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
                chk("grant", 32'(grant), 32'(eg));
                chk("m_tvalid", 32'(m_tvalid),
                    32'((own == 1) ? up_tvalid : (own == 2) ? la_tvalid : 1'b0));
                chk("up_tready", 32'(up_tready), 32'(own == 1 && m_tready));
                chk("la_tready", 32'(la_tready), 32'(own == 2 && m_tready));
                chk("err_timeout", 32'(err_timeout), 32'(err_m));
                chk("strb_keep", {24'd0, m_tstrb, m_tkeep}, 32'h0000_00FF);
                if (own == 0) begin
                    chk("idle_tdata", m_tdata, 32'd0);
                    chk("idle_tlast", 32'(m_tlast), 32'd0);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", m_tdata, e.data);
                        chk("tuser", 32'(m_tuser), 32'(e.user));
                        chk("tlast", 32'(m_tlast), 32'(e.last));
                        chk("beat_grant", 32'(grant), 32'(e.gnt));
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        axis_rst = 1'b1; arb_en = 1'b1; la_hpri_req = 1'b0; err_clr = 1'b0;
        m_tready = 1'b0; up_tvalid = 1'b0; la_tvalid = 1'b0;
        up_tdata = '0; la_tdata = '0; up_tuser = '0; la_tuser = '0;
        up_tlast = 1'b0; la_tlast = 1'b0;
        cycle();
        mon_en = 1'b1;
        cycle();
        axis_rst = 1'b0;
        repeat (2) cycle();

        // UP-only, then LA-only, 3-beat packets back to back.
        for (int i = 0; i < 4; i++) add_pkt(1, 3);
        drain(200);
        for (int i = 0; i < 4; i++) add_pkt(2, 3);
        drain(200);

        // Fair alternation from a fresh reset: UP must win the first tie.
        reset_dut();
        for (int i = 0; i < 3; i++) begin add_pkt(1, 4); add_pkt(2, 4); end
        drain(300);

        // Constant high-priority request with both streaming 2-beat packets.
        la_hpri_req = 1'b1;
        for (int i = 0; i < 3; i++) add_pkt(1, 2);
        for (int i = 0; i < 10; i++) add_pkt(2, 2);
        drain(400);
        la_hpri_req = 1'b0;

        // Runaway UP packet: forced tlast on beat 64, LA wins next, then clear.
        add_pkt(1, 100);
        add_pkt(2, 4);
        drain(400);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        repeat (2) cycle();

        // Randomized traffic, backpressure, valid gaps, arb_en and hpri toggling.
        up_pct = 70; la_pct = 70; rdy_pct = 60; rnd_ctl = 1'b1;
        for (int i = 0; i < 25; i++) begin
            add_pkt(1, ($urandom_range(9) == 0) ? 70 : $urandom_range(1, 8));
            add_pkt(2, ($urandom_range(9) == 0) ? 70 : $urandom_range(1, 8));
        end
        drain(20000);
        rnd_ctl = 1'b0; arb_en = 1'b1; la_hpri_req = 1'b0; err_clr = 1'b0;
        up_pct = 100; la_pct = 100; rdy_pct = 100;
        repeat (2) cycle();

        // Reset while beat 2 of a 4-beat LA packet transfers.
        add_pkt(2, 4);
        guard = 0;
        while (!(own == 2 && remain == 3) && guard < 50) begin cycle(); guard++; end
        chk("reset_setup_reached", 32'(guard < 50), 32'd1);
        reset_dut();
        add_pkt(1, 2);
        add_pkt(2, 2);
        cycle();
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
